// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and defaults for the CPU memory arbiter
package cpu_mem_pkg;

    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 8;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Latency counter width: enough to hold LAT, never narrower than one bit.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       winner
);

    // req[0] is IF, req[1] is D; on contention the side that did not win last time goes
    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            winner = ~last_grant;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares the single-port CPU memory between fetch and load/store
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          last_grant
);

    localparam int CW = cnt_width(LAT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          last_grant_q, last_grant_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;

    logic          gnt_valid;
    logic          winner;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, if_req}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .winner     (winner)
    );

    // Next-state logic: grant, issue, wait out the memory latency, acknowledge
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d      = owner_t'(winner);
                    addr_d       = winner ? d_addr : if_addr;
                    we_d         = winner ? d_we : 1'b0;
                    wdata_d      = winner ? d_wdata : '0;
                    last_grant_d = winner;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = CW'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    if_ack_d = (owner_q == OWN_IF);
                    d_ack_d  = (owner_q == OWN_D);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Memory bus is driven only in the issue cycle and is all-zero otherwise
    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = mem_en ? we_q : 1'b0;
        mem_addr  = mem_en ? addr_q : '0;
        mem_wdata = mem_en ? wdata_q : '0;
    end

    assign if_ack     = if_ack_q;
    assign d_ack      = d_ack_q;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - scoreboard bench for the CPU memory arbiter
module tb_cpu_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_ack;
    logic [7:0] if_rdata;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       last_grant;

    cpu_mem_arbiter #(.AW(8), .DW(8), .LAT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: unwritten locations read as addr ^ 8'hA5, LAT=2 read pipeline
    bit         wr_vld [256];
    logic [7:0] wr_dat [256];
    logic [7:0] pipe1 = 8'h00;
    logic [7:0] pipe2 = 8'h00;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_vld[mem_addr] <= 1'b1;
            wr_dat[mem_addr] <= mem_wdata;
        end
        if (mem_en) pipe1 <= wr_vld[mem_addr] ? wr_dat[mem_addr] : (mem_addr ^ 8'hA5);
        else        pipe1 <= 8'h00;
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit         own;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit own, input logic [7:0] rdata);
        exp_t e;
        e.own   = own;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    int         men_cnt = 0;
    int         men_cyc = 0;
    logic [7:0] men_addr = 8'h00;
    logic [7:0] men_wdata = 8'h00;
    logic       men_we = 1'b0;
    int         ack_cnt = 0;
    bit         alt_on = 1'b0;
    bit         alt_have = 1'b0;
    int         prev_ack_cyc = 0;
    bit         prev_own = 1'b0;

    // monitor: logs memory issues and pops the scoreboard on every ack
    always @(negedge clk) begin
        exp_t e;
        if (mem_en) begin
            men_cnt++;
            men_cyc   = cyc;
            men_addr  = mem_addr;
            men_wdata = mem_wdata;
            men_we    = mem_we;
        end else begin
            chk("idle_bus", {15'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
        end
        if (!alt_on) alt_have = 1'b0;
        if (if_ack || d_ack) begin
            ack_cnt++;
            if (if_ack && d_ack) chk("dual_ack", 1, 0);
            if (sb.size() == 0) begin
                chk("unexp_ack", {30'd0, if_ack, d_ack}, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {31'd0, d_ack}, {31'd0, e.own});
                chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
            end
            if (alt_on) begin
                if (alt_have) begin
                    chk("ack_gap", cyc - prev_ack_cyc, 5);
                    chk("ack_alt", {31'd0, d_ack == prev_own}, 0);
                end
                alt_have     = 1'b1;
                prev_ack_cyc = cyc;
                prev_own     = d_ack;
            end
        end
    end

    task automatic wait_ack(input bit own, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((!own && if_ack) || (own && d_ack)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int at;
        int mc0;
        int ac0;

        // reset with both requests asserted
        reset_n = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 8'h0A;
        d_addr  = 8'h0B;
        d_we    = 1'b0;
        d_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_acks", {if_ack, d_ack}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_grant", last_grant, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        t0 = cyc;
        push(1'b0, 8'h0A ^ 8'hA5);
        push(1'b1, 8'h0B ^ 8'hA5);
        wait_ack(1'b0, at);
        if_req = 1'b0;
        chk("t1_if_first_cyc", at, t0 + 4);
        wait_ack(1'b1, at);
        d_req = 1'b0;

        // single IF read
        if_req  = 1'b1;
        if_addr = 8'h10;
        t0  = cyc;
        mc0 = men_cnt;
        push(1'b0, 8'hB5);
        wait_ack(1'b0, at);
        if_req = 1'b0;
        chk("t2_ack_cyc", at, t0 + 4);
        chk("t2_men_cyc", men_cyc, t0 + 1);
        chk("t2_men_cnt", men_cnt - mc0, 1);
        chk("t2_men_addr", men_addr, 8'h10);

        // simultaneous IF and D reads after reset
        do_reset();
        if_req  = 1'b1;
        if_addr = 8'h01;
        d_req   = 1'b1;
        d_addr  = 8'h02;
        d_we    = 1'b0;
        t0 = cyc;
        push(1'b0, 8'hA4);
        push(1'b1, 8'hA7);
        wait_ack(1'b0, at);
        if_req = 1'b0;
        chk("t3_if_ack_cyc", at, t0 + 4);
        @(negedge clk);
        @(negedge clk);
        chk("t3_last_grant", last_grant, 1);
        wait_ack(1'b1, at);
        d_req = 1'b0;
        chk("t3_d_ack_cyc", at, t0 + 9);
        chk("t3_d_men_cyc", men_cyc, t0 + 6);

        // D write leaves d_rdata unchanged
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 8'h20;
        d_wdata = 8'h3C;
        push(1'b1, 8'hA7);
        wait_ack(1'b1, at);
        d_req = 1'b0;
        d_we  = 1'b0;
        chk("t4_men_we", men_we, 1);
        chk("t4_men_addr", men_addr, 8'h20);
        chk("t4_men_wdata", men_wdata, 8'h3C);

        // read back; payload changed after grant must be ignored
        d_req  = 1'b1;
        d_addr = 8'h20;
        push(1'b1, 8'h3C);
        @(posedge clk);
        #1;
        d_addr = 8'h77;
        wait_ack(1'b1, at);
        d_req = 1'b0;
        chk("t4_rd_men_addr", men_addr, 8'h20);

        // both held: strict alternation, five cycles apart
        do_reset();
        if_addr = 8'h33;
        d_addr  = 8'h44;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push(1'b0, 8'h33 ^ 8'hA5);
            else            push(1'b1, 8'h44 ^ 8'hA5);
        end
        ac0    = ack_cnt;
        alt_on = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        alt_on = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_ack_count", ack_cnt - ac0, 8);
        chk("t5_sb_empty", sb.size(), 0);

        // reset during WAIT of a D read
        do_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 8'h55;
        repeat (2) @(posedge clk);
        #2;
        chk("t6_busy_in_wait", busy, 1);
        ac0 = ack_cnt;
        reset_n = 1'b0;
        #1;
        chk("t6_abort_bus", {mem_en, d_ack, if_ack}, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_lg", last_grant, 1);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_ack", ack_cnt - ac0, 0);
        if_req  = 1'b1;
        if_addr = 8'h01;
        d_req   = 1'b1;
        d_addr  = 8'h02;
        t0 = cyc;
        push(1'b0, 8'hA4);
        push(1'b1, 8'hA7);
        wait_ack(1'b0, at);
        if_req = 1'b0;
        chk("t6_if_first_cyc", at, t0 + 4);
        wait_ack(1'b1, at);
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Two-requester arbiter that shares the single-port 8-bit CPU memory between the instruction-fetch path (IF, read-only) and the data load/store path (D). It latches one request at a time and drives the memory for one issue cycle. It waits a fixed memory latency, captures read data and returns a one-cycle ack to the owner. Contention is resolved round-robin. The block sits between the cpu core's fetch/LSU logic and the memory model.

Parameters:
AW, 8, address width
DW, 8, data width
LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata (legal range LAT >= 1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  IF request, held until if_ack
if_addr  in  AW  IF read address
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DW  IF read data, valid with if_ack, held afterwards
d_req  in  1  D request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  D address
d_wdata  in  DW  D write data
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DW  D read data, valid with d_ack, held afterwards
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle
busy  out  1  state != IDLE
last_grant  out  1  owner of the most recent grant (0 = IF, 1 = D)

Behaviour:
- Reset (async, reset_n=0):
  - State becomes IDLE; counter cleared.
  - All outputs are 0, except last_grant = 1, so IF wins the first contention.
  - Owner, address, we and wdata holding registers are cleared.
- FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant it. With both, grant the requester != last_grant.
  - At grant: latch owner, addr, we (forced 0 for IF) and wdata; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latched registers.
  - Load counter with LAT-1; go to WAIT.
- WAIT (LAT cycles):
  - Decrement the counter each cycle.
  - When counter == 0: capture mem_rdata into the owner's rdata register if this is a read (writes leave rdata unchanged); go to DONE.
- DONE (1 cycle): owner's ack = 1; all requests ignored this cycle; go to IDLE.
- Latency: request first seen in IDLE cycle T0 -> mem_en in T0+1 -> mem_rdata sampled at end of T0+1+LAT -> ack in T0+LAT+2.
- Throughput: one access every LAT+3 cycles; a held req is re-evaluated in the IDLE cycle after DONE.
- mem_addr, mem_we and mem_wdata are 0 whenever mem_en = 0.
- Request dropped before grant: nothing happens.
- Request dropped after grant: the access still completes and ack still pulses.
- Payload changes after grant: ignored, because the latched copy is used.
- reset_n asserted in any state: aborts immediately; mem_en and ack go to 0 in the same instant; no ack is issued for the aborted access after release.
- Width rules: no arithmetic on data. Counter width is $clog2(LAT+1), minimum 1.

Decomposition:
- Package cpu_mem_pkg:
  - typedef enum state_t {IDLE, ACCESS, WAIT, DONE}
  - typedef enum logic owner_t {OWN_IF=0, OWN_D=1}
  - Default AW/DW constants
- One sub-module, rr_arb2: combinational 2-way round-robin pick. Inputs: req[1:0], last_grant. Outputs: grant valid, winner.
- The FSM, counter and registers stay in cpu_mem_arbiter.

Test Plan:
1. Reset: hold reset_n=0 with both reqs high -> all outputs 0, last_grant=1, busy=0. Release -> IF granted first.
2. Single IF read, LAT=2, memory model returns addr^8'hA5; if_req with if_addr=8'h10 at cycle 0 -> mem_en=1 and mem_addr=8'h10 in cycle 1 only; if_ack pulse in cycle 4 with if_rdata=8'hB5; d_ack stays 0.
3. Simultaneous IF read 8'h01 and D read 8'h02 from cycle 0 (after reset) -> IF acked cycle 4 (if_rdata=8'hA4); D mem_en cycle 6, d_ack cycle 9, d_rdata=8'hA7; last_grant=1 after cycle 5.
4. D write, d_addr=8'h20, d_wdata=8'h3C -> ACCESS cycle shows mem_en=1, mem_we=1, mem_addr=8'h20, mem_wdata=8'h3C; d_ack pulses; d_rdata keeps its prior value.
5. Both reqs held high for 40 cycles -> grants alternate IF, D, IF, D; acks spaced exactly 5 cycles apart (LAT=2); never two consecutive acks to the same owner.
6. reset_n pulsed low during WAIT of a D read -> mem_en/d_ack 0 immediately; no d_ack after release; the next contention grants IF.
